// File: rtl/sd_sector_ctrl_if.sv
// CPU-side bus bundle for sd_sector_ctrl: single-cycle read/write strobes and a
// registered read return with a one-cycle valid pulse.
interface sd_sector_ctrl_if;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        bus_read_valid;

    modport master (
        output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        input  bus_read_data, bus_read_valid
    );

    modport slave (
        input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        output bus_read_data, bus_read_valid
    );
endinterface

// File: rtl/sd_sector_ctrl.sv
// Sequences single-sector reads from sd_controller into a local 512-byte buffer and
// exposes ADDR/CMD/STATUS registers plus a read-only buffer window on the CPU bus.
module sd_sector_ctrl #(
    parameter logic [63:0] REG_BASE       = 64'h0000_0000_0000_2000,
    parameter logic [63:0] BUF_BASE       = 64'h0000_0000_0000_3000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    sd_sector_ctrl_if.slave  bus,
    output logic             sd_rd,
    output logic [31:0]      sd_address,
    input  logic [7:0]       sd_dout,
    input  logic             sd_byte_available,
    input  logic             sd_ready,
    output logic             irq_done
);
    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StWaitReady = 3'd1;
    localparam logic [2:0] StIssue     = 3'd2;
    localparam logic [2:0] StRecv      = 3'd3;
    localparam logic [2:0] StDone      = 3'd4;
    localparam logic [2:0] StErr       = 3'd5;
    localparam logic [9:0] SectorBytes = 10'd512;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic        avail_q, avail_d;
    logic        err_q, err_d;
    logic [23:0] tmo_q, tmo_d;
    logic        byte_avail_q;
    logic        rvalid_q, rvalid_d;
    logic [63:0] reg_rdata_q, reg_rdata_d;
    logic        buf_sel_q, buf_sel_d;
    logic [7:0]  buf_rdata_q;
    logic [7:0]  mem [512];

    logic [8:0]  buf_off;
    logic        hit_addr, hit_cmd, hit_status, hit_buf;
    logic        wr_addr, wr_cmd, byte_edge, buf_we;
    logic        unused_wdata;

    assign unused_wdata = ^bus.bus_write_data[63:32];

    always_comb begin
        buf_off    = 9'(bus.bus_address - BUF_BASE);
        hit_addr   = bus.bus_address == REG_BASE;
        hit_cmd    = bus.bus_address == REG_BASE + 64'd8;
        hit_status = bus.bus_address == REG_BASE + 64'd16;
        hit_buf    = (bus.bus_address >= BUF_BASE) && (bus.bus_address < BUF_BASE + 64'd512);
        wr_addr    = bus.bus_write_enable && hit_addr;
        wr_cmd     = bus.bus_write_enable && hit_cmd;
        byte_edge  = sd_byte_available && !byte_avail_q;
        // The count guard keeps late edges from wrapping onto buf[0].
        buf_we     = !reset && (state_q == StRecv) && byte_edge && (byte_cnt_q < SectorBytes);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        avail_d    = avail_q;
        err_d      = err_q;
        tmo_d      = '0;
        case (state_q)
            StIdle: begin
                if (wr_addr) addr_d = bus.bus_write_data[31:0];
                if (wr_cmd && bus.bus_write_data[0]) begin
                    avail_d    = 1'b0;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = StWaitReady;
                end
            end
            StWaitReady: begin
                tmo_d = tmo_q + 24'd1;
                if (sd_ready) state_d = StIssue;
                else if (tmo_d == TIMEOUT_CYCLES) state_d = StErr;
            end
            StIssue: begin
                tmo_d = tmo_q + 24'd1;
                if (!sd_ready) state_d = StRecv;
                else if (tmo_d == TIMEOUT_CYCLES) state_d = StErr;
            end
            StRecv: begin
                tmo_d = tmo_q + 24'd1;
                if (byte_edge) begin
                    tmo_d = '0;
                    if (byte_cnt_q < SectorBytes) byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_q == SectorBytes - 10'd1) state_d = StDone;
                end else if (tmo_d == TIMEOUT_CYCLES) begin
                    state_d = StErr;
                end
            end
            StDone: begin
                avail_d = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                err_d   = 1'b1;
                avail_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (wr_cmd && bus.bus_write_data[1]) err_d = 1'b0;
        if (state_d != state_q) tmo_d = '0;
    end

    // Read data comes from the current (pre-write) register values.
    always_comb begin
        rvalid_d    = bus.bus_read_enable && (hit_addr || hit_cmd || hit_status || hit_buf);
        buf_sel_d   = bus.bus_read_enable && hit_buf;
        reg_rdata_d = '0;
        if (bus.bus_read_enable && hit_addr) begin
            reg_rdata_d = {32'd0, addr_q};
        end else if (bus.bus_read_enable && hit_status) begin
            reg_rdata_d = {38'd0, byte_cnt_q, 12'd0, err_q, avail_q, state_q != StIdle, sd_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            avail_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            byte_avail_q <= 1'b0;
            rvalid_q     <= 1'b0;
            reg_rdata_q  <= '0;
            buf_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            avail_q      <= avail_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            byte_avail_q <= sd_byte_available;
            rvalid_q     <= rvalid_d;
            reg_rdata_q  <= reg_rdata_d;
            buf_sel_q    <= buf_sel_d;
        end
    end

    // Separate write and read ports so the buffer maps onto a dual-port RAM.
    always_ff @(posedge clk) begin
        if (buf_we) mem[byte_cnt_q[8:0]] <= sd_dout;
        buf_rdata_q <= mem[buf_off];
    end

    assign bus.bus_read_data  = buf_sel_q ? {56'd0, buf_rdata_q} : reg_rdata_q;
    assign bus.bus_read_valid = rvalid_q;
    assign sd_rd              = state_q == StIssue;
    assign sd_address         = addr_q;
    assign irq_done           = state_q == StDone;
endmodule
